// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU: opcodes, FSM states, ALU selects and
// the signed skip-condition decode.
package cpu_pkg;

  localparam int unsigned OP_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h7,
    OP_SKIP  = 4'h8,
    OP_JUMP  = 4'h9,
    OP_CLEAR = 4'hA
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    FETCH_C,
    EXEC,
    MEM_WAIT,
    ALU_WB,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB
  } alu_op_t;

  localparam logic [1:0] SK_NEG  = 2'b00;
  localparam logic [1:0] SK_ZERO = 2'b01;
  localparam logic [1:0] SK_POS  = 2'b10;

  // AC is treated as two's complement; condition 11 never skips.
  function automatic logic skip_taken(input logic [1:0] cond, input logic ac_neg,
                                      input logic ac_zero);
    logic taken;
    taken = 1'b0;
    case (cond)
      SK_NEG:  taken = ac_neg;
      SK_ZERO: taken = ac_zero;
      SK_POS:  taken = !ac_neg && !ac_zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/accum_cpu_alu.sv
// Combinational accumulator ALU: pass-through, add or subtract, wrapping
// modulo 2^DATA_WIDTH.
module accum_cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  alu_op_t               alu_op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result_c
);

  always_comb begin
    result_c = b;
    case (alu_op)
      ALU_ADD: result_c = a + b;
      ALU_SUB: result_c = a - b;
      default: result_c = b;
    endcase
  end

endmodule

// File: rtl/accum_cpu_core.sv
// Two-word-instruction accumulator CPU. A single FSM fetches, decodes and
// executes while driving a synchronous single-port RAM directly.
module accum_cpu_core
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  halted,
  output logic                  retired,
  output logic                  illegal_op,
  output logic [ADDR_WIDTH-1:0] pc_dbg,
  output logic [DATA_WIDTH-1:0] ac_dbg
);

  if (ADDR_WIDTH > DATA_WIDTH || DATA_WIDTH < 8) begin : g_param_check
    $error("accum_cpu_core: requires DATA_WIDTH >= 8 and ADDR_WIDTH <= DATA_WIDTH");
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d;
  logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
  logic [DATA_WIDTH-1:0] ir1_q, ir1_d;
  logic [DATA_WIDTH-1:0] ir2_q, ir2_d;
  logic                  illegal_q, illegal_d;

  logic [OP_WIDTH-1:0]   op;
  logic [1:0]            cond;
  logic [ADDR_WIDTH-1:0] operand;
  alu_op_t               alu_op;
  logic [DATA_WIDTH-1:0] alu_result_c;
  logic                  unused_ir;

  assign op        = ir1_q[DATA_WIDTH-1 -: OP_WIDTH];
  assign cond      = ir1_q[1:0];
  assign operand   = ir2_q[ADDR_WIDTH-1:0];
  assign unused_ir = ^{ir1_q[DATA_WIDTH-OP_WIDTH-1:2], ir2_q};

  assign pc_dbg     = pc_q;
  assign ac_dbg     = ac_q;
  assign illegal_op = illegal_q;

  always_comb begin
    alu_op = ALU_PASS;
    case (op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      default: alu_op = ALU_PASS;
    endcase
  end

  accum_cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .alu_op  (alu_op),
    .a       (ac_q),
    .b       (mbr_q),
    .result_c(alu_result_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      ac_q      <= '0;
      mbr_q     <= '0;
      ir1_q     <= '0;
      ir2_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ac_q      <= ac_d;
      mbr_q     <= mbr_d;
      ir1_q     <= ir1_d;
      ir2_q     <= ir2_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state, datapath updates and memory strobes, all keyed off state_q.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ac_d      = ac_q;
    mbr_d     = mbr_q;
    ir1_d     = ir1_q;
    ir2_d     = ir2_q;
    illegal_d = illegal_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    halted    = 1'b0;
    retired   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH_A;
      end
      FETCH_A: begin
        mem_addr = pc_q;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        state_d  = FETCH_B;
      end
      FETCH_B: begin
        mem_addr = pc_q + ADDR_WIDTH'(1);
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        ir1_d    = mem_rdata;
        state_d  = FETCH_C;
      end
      FETCH_C: begin
        ir2_d   = mem_rdata;
        pc_d    = pc_q + ADDR_WIDTH'(2);
        state_d = EXEC;
      end
      EXEC: begin
        retired = 1'b1;
        state_d = FETCH_A;
        case (op)
          OP_LOAD, OP_ADD, OP_SUB: begin
            mem_addr = operand;
            mem_cs   = 1'b1;
            mem_oe   = 1'b1;
            retired  = 1'b0;
            state_d  = MEM_WAIT;
          end
          OP_STORE: begin
            mem_addr  = operand;
            mem_wdata = ac_q;
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
          end
          OP_HALT:  state_d = HALT;
          OP_SKIP: begin
            if (skip_taken(cond, ac_q[DATA_WIDTH-1], ac_q == '0)) pc_d = pc_q + ADDR_WIDTH'(2);
          end
          OP_JUMP:  pc_d = operand;
          OP_CLEAR: ac_d = '0;
          default:  illegal_d = 1'b1;
        endcase
      end
      MEM_WAIT: begin
        mbr_d   = mem_rdata;
        state_d = ALU_WB;
      end
      ALU_WB: begin
        ac_d    = alu_result_c;
        retired = 1'b1;
        state_d = FETCH_A;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_accum_cpu_core.sv
// Directed bench for accum_cpu_core: an 8-bit core and a 16-bit core, each on a
// behavioural synchronous RAM that the bench preloads before pulsing start.
module tb_accum_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit instance
  logic       rst, start;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_cs, mem_we, mem_oe, halted, retired, illegal_op;
  logic [7:0] pc_dbg, ac_dbg;
  logic [7:0] mem [256];
  logic       ld_we;
  logic [7:0] ld_addr, ld_data;
  logic [7:0] prog [$];

  // 16-bit instance
  logic        rst_w, start_w;
  logic [7:0]  w_addr;
  logic [15:0] w_wdata, w_rdata;
  logic        w_cs, w_we, w_oe, w_halted, w_retired, w_illegal;
  logic [7:0]  w_pc;
  logic [15:0] w_ac;
  logic [15:0] mem_w [256];
  logic        ld_w_we;
  logic [7:0]  ld_w_addr;
  logic [15:0] ld_w_data;

  accum_cpu_core #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .START_ADDR(8'h00)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .halted(halted), .retired(retired), .illegal_op(illegal_op), .pc_dbg(pc_dbg),
    .ac_dbg(ac_dbg)
  );

  accum_cpu_core #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .START_ADDR(8'h00)) u_dut_w (
    .clk(clk), .rst(rst_w), .start(start_w), .mem_addr(w_addr), .mem_wdata(w_wdata),
    .mem_rdata(w_rdata), .mem_cs(w_cs), .mem_we(w_we), .mem_oe(w_oe),
    .halted(w_halted), .retired(w_retired), .illegal_op(w_illegal), .pc_dbg(w_pc),
    .ac_dbg(w_ac)
  );

  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (ld_w_we) mem_w[ld_w_addr] <= ld_w_data;
    else if (w_cs && w_we) mem_w[w_addr] <= w_wdata;
    if (w_cs && w_oe) w_rdata <= mem_w[w_addr];
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic poke_w(input logic [7:0] a, input logic [15:0] d);
    ld_w_we = 1'b1; ld_w_addr = a; ld_w_data = d;
    @(negedge clk);
    ld_w_we = 1'b0;
  endtask

  // Holds the core in reset, clears RAM and loads prog at address 0.
  task automatic setup_prog();
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
    for (int i = 0; i < prog.size(); i++) poke(8'(i), prog[i]);
  endtask

  task automatic release_and_start();
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_retire(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retired && n < 20);
    checks++;
    if (retired !== 1'b1) begin
      errors++;
      $display("FAIL %s_retire: retired=%b after %0d cycles, expected 1", tag, retired, n);
    end
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_halt: halted=%b after %0d cycles, expected 1", tag, halted, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_cs, mem_we, mem_oe} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: cs/we/oe=%b expected 000", {mem_cs, mem_we, mem_oe});
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h expected 00 00", mem_addr, mem_wdata);
    end
    checks++;
    if ({halted, retired, illegal_op} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: halted/retired/illegal=%b expected 000",
               {halted, retired, illegal_op});
    end
    checks++;
    if (pc_dbg !== 8'h00 || ac_dbg !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs: pc=%h ac=%h expected 00 00", pc_dbg, ac_dbg);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (mem_cs !== 1'b0 || pc_dbg !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: cs=%b pc=%h expected 0 00 without start", mem_cs, pc_dbg);
    end
  endtask

  task automatic test_fibonacci();
    prog = '{8'h10, 8'h1C, 8'h30, 8'h1D, 8'h30, 8'h1E, 8'h20, 8'h1F,
             8'h10, 8'h1D, 8'h20, 8'h1E, 8'h10, 8'h1F, 8'h20, 8'h1D,
             8'h10, 8'h20, 8'h40, 8'h21, 8'h20, 8'h20, 8'h81, 8'h00,
             8'h90, 8'h00, 8'h70, 8'h00,
             8'h00, 8'h01, 8'h00, 8'h00, 8'h0B, 8'h01};
    setup_prog();
    release_and_start();
    wait_halt("fib", 3000);
    checks++;
    if (mem[8'h1F] !== 8'h90 || mem[8'h1D] !== 8'h90) begin
      errors++;
      $display("FAIL fib_sum: mem1F=%h mem1D=%h expected 90 90", mem[8'h1F], mem[8'h1D]);
    end
    checks++;
    if (mem[8'h1E] !== 8'h59 || mem[8'h20] !== 8'h00) begin
      errors++;
      $display("FAIL fib_prev_ctr: mem1E=%h mem20=%h expected 59 00", mem[8'h1E], mem[8'h20]);
    end
    checks++;
    if (pc_dbg !== 8'h1C || illegal_op !== 1'b0 || ac_dbg !== 8'h00) begin
      errors++;
      $display("FAIL fib_final: pc=%h illegal=%b ac=%h expected 1C 0 00",
               pc_dbg, illegal_op, ac_dbg);
    end
  endtask

  task automatic test_sub_skip();
    prog = '{8'h40, 8'h40, 8'h80, 8'h00, 8'h70, 8'h00, 8'h82, 8'h00, 8'h70, 8'h00};
    setup_prog();
    poke(8'h40, 8'h01);
    release_and_start();
    wait_retire("sub");
    @(negedge clk);
    checks++;
    if (ac_dbg !== 8'hFF) begin
      errors++;
      $display("FAIL sub_wrap: ac=%h expected FF", ac_dbg);
    end
    wait_retire("skip_neg");
    @(negedge clk);
    checks++;
    if (pc_dbg !== 8'h06) begin
      errors++;
      $display("FAIL skip_neg_taken: pc=%h expected 06", pc_dbg);
    end
    wait_retire("skip_pos");
    @(negedge clk);
    checks++;
    if (pc_dbg !== 8'h08 || ac_dbg !== 8'hFF) begin
      errors++;
      $display("FAIL skip_pos_not_taken: pc=%h ac=%h expected 08 FF", pc_dbg, ac_dbg);
    end
    wait_halt("sub_skip", 20);
    checks++;
    if (pc_dbg !== 8'h0A) begin
      errors++;
      $display("FAIL sub_skip_halt_pc: pc=%h expected 0A", pc_dbg);
    end
  endtask

  task automatic test_store_timing();
    int cyc, ret_cyc, we_cnt;
    logic [7:0] we_addr, we_data;
    logic we_oe, we_cs;
    prog = '{8'h10, 8'h40, 8'h20, 8'h30, 8'h70, 8'h00};
    setup_prog();
    poke(8'h40, 8'h5A);
    release_and_start();
    checks++;
    if (mem_cs !== 1'b1 || mem_oe !== 1'b1 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL first_fetch: cs=%b oe=%b addr=%h expected 1 1 00", mem_cs, mem_oe, mem_addr);
    end
    cyc = 1;
    while (!retired && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("FAIL load_cycles: retired at cycle %0d expected 6", cyc);
    end
    cyc = 0; ret_cyc = 0; we_cnt = 0;
    we_addr = 8'h00; we_data = 8'h00; we_oe = 1'b1; we_cs = 1'b0;
    while (halted !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr; we_data = mem_wdata; we_oe = mem_oe; we_cs = mem_cs;
      end
      if (retired && ret_cyc == 0) ret_cyc = cyc;
    end
    checks++;
    if (ret_cyc != 4 || we_cnt != 1) begin
      errors++;
      $display("FAIL store_timing: retire cycle %0d we cycles %0d expected 4 1", ret_cyc, we_cnt);
    end
    checks++;
    if (we_addr !== 8'h30 || we_data !== 8'h5A || we_oe !== 1'b0 || we_cs !== 1'b1) begin
      errors++;
      $display("FAIL store_bus: addr=%h wdata=%h oe=%b cs=%b expected 30 5A 0 1",
               we_addr, we_data, we_oe, we_cs);
    end
    checks++;
    if (mem[8'h30] !== 8'h5A || halted !== 1'b1) begin
      errors++;
      $display("FAIL store_mem: mem30=%h halted=%b expected 5A 1", mem[8'h30], halted);
    end
  endtask

  task automatic test_reset_mid_store();
    prog = '{8'h10, 8'h40, 8'h20, 8'h31};
    setup_prog();
    poke(8'h40, 8'h5A);
    poke(8'h31, 8'h11);
    release_and_start();
    wait_retire("mid_load");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_addr !== 8'h03 || ac_dbg !== 8'h5A) begin
      errors++;
      $display("FAIL mid_fetch: addr=%h ac=%h expected 03 5A", mem_addr, ac_dbg);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || mem_cs !== 1'b0 || pc_dbg !== 8'h00 || ac_dbg !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: we=%b cs=%b pc=%h ac=%h expected 0 0 00 00",
               mem_we, mem_cs, pc_dbg, ac_dbg);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_cs !== 1'b0 || mem[8'h31] !== 8'h11) begin
      errors++;
      $display("FAIL mid_idle_mem: cs=%b mem31=%h expected 0 11", mem_cs, mem[8'h31]);
    end
  endtask

  task automatic test_wrap_illegal();
    prog = '{8'h90, 8'hFE};
    setup_prog();
    poke(8'hFE, 8'h50);
    poke(8'hFF, 8'h00);
    release_and_start();
    wait_retire("jump");
    @(negedge clk);
    checks++;
    if (pc_dbg !== 8'hFE || mem_addr !== 8'hFE) begin
      errors++;
      $display("FAIL jump_target: pc=%h addr=%h expected FE FE", pc_dbg, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (mem_addr !== 8'hFF) begin
      errors++;
      $display("FAIL fetch_b_addr: addr=%h expected FF", mem_addr);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (retired !== 1'b1) begin
      errors++;
      $display("FAIL illegal_retire: retired=%b expected 1 on 4th cycle", retired);
    end
    @(negedge clk);
    checks++;
    if (pc_dbg !== 8'h00 || illegal_op !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL pc_wrap_illegal: pc=%h illegal=%b halted=%b expected 00 1 0",
               pc_dbg, illegal_op, halted);
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_cs !== 1'b1) begin
      errors++;
      $display("FAIL continue_fetch: addr=%h cs=%b expected 00 1", mem_addr, mem_cs);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_retire("jump_again");
    @(negedge clk);
    checks++;
    if (pc_dbg !== 8'hFE || illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: pc=%h illegal=%b expected FE 1", pc_dbg, illegal_op);
    end
  endtask

  task automatic test_wide();
    int n;
    rst_w = 1'b1; start_w = 1'b0;
    poke_w(8'h00, 16'h1000); poke_w(8'h01, 16'h0010);
    poke_w(8'h02, 16'h3000); poke_w(8'h03, 16'h0010);
    poke_w(8'h04, 16'h8001); poke_w(8'h05, 16'h0000);
    poke_w(8'h06, 16'h7000); poke_w(8'h07, 16'h0000);
    poke_w(8'h08, 16'h7000); poke_w(8'h09, 16'h0000);
    poke_w(8'h10, 16'h8000);
    rst_w = 1'b0;
    @(negedge clk);
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    n = 0;
    while (w_halted !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (w_halted !== 1'b1 || w_ac !== 16'h0000) begin
      errors++;
      $display("FAIL wide_add_wrap: halted=%b ac=%h expected 1 0000", w_halted, w_ac);
    end
    checks++;
    if (w_pc !== 8'h0A || w_illegal !== 1'b0) begin
      errors++;
      $display("FAIL wide_skip_zero: pc=%h illegal=%b expected 0A 0", w_pc, w_illegal);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    rst_w = 1'b1; start_w = 1'b0; ld_w_we = 1'b0; ld_w_addr = '0; ld_w_data = '0;
    @(negedge clk);
    test_reset();
    test_fibonacci();
    test_sub_skip();
    test_store_timing();
    test_reset_mid_store();
    test_wrap_illegal();
    test_reset();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
